serial_pattern_gen: RTL and testbench
=====================================

# serial_pattern_gen

Serial bit-stream generator that loads a parallel word on a start request and shifts it out MSB-first, one bit per clock, on a single-bit line. It is the transmit-side counterpart of the serial "more than one 1" detector FSMs. It drives their `in` stimulus in self-checking system benches and in the serial link demo. It tracks how many `1`s it has emitted and flags when more than one has gone out, so a downstream detector can be checked against it cycle by cycle.

## Interface
- `WIDTH`, default 8: parallel word width; legal range 2–32.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  load request; sampled only in IDLE.
- `data`  input  WIDTH  word to serialize; captured on the accepting edge.
- `out`  output  1  serial bit line.
- `busy`  output  1  high while bits (and parity, if enabled) are being driven.
- `done`  output  1  one-cycle pulse after the last bit.
- `ones_cnt`  output  $clog2(WIDTH+1)  number of `1` data bits fully emitted so far this frame.
- `multi`  output  1  `ones_cnt >= 2`.

## Operation
- The FSM has four states: IDLE, SHIFT, PARITY, DONE.
- **IDLE**
  - `start`=1 on an edge: capture `data` into the shift register, clear `ones_cnt` and the bit counter, go to SHIFT.
  - `start`=0: stay in IDLE.
- **SHIFT**
  - `out` = shift-register MSB.
  - Each edge shifts the register left, increments the bit counter, and adds the emitted bit to `ones_cnt`.
  - After WIDTH bits: go to PARITY if enabled, otherwise go to DONE.
- **PARITY** (lasts one cycle): `out` = XOR of all WIDTH data bits (even parity: total ones including parity is even).
- **DONE** (lasts one cycle): `out`=0, `done`=1, then go to IDLE.
- `start` in SHIFT, PARITY or DONE is ignored; no queuing.
- If `start` is held high continuously, a new frame is accepted on the first IDLE edge after DONE.
- `ones_cnt` and `multi` hold their final values through DONE and IDLE until the next accepted start.
- `data` changes after the accepting edge have no effect on the current frame.
- `busy` = state is SHIFT or PARITY.
- Outputs are driven from registered state only; there is no combinational path from `start` or `data` to any output.

## Timing
- Reset value (asynchronous, immediate): state IDLE; `out`=0, `busy`=0, `done`=0, `ones_cnt`=0, `multi`=0; shift register 0.
- Reset asserted mid-frame: the frame is abandoned with no `done` pulse. Operation resumes in IDLE on the first edge after `rst` deasserts.
- Start accepted at edge k:
  - `data[WIDTH-1-i]` is on `out` during cycle k+i, for i = 0..WIDTH-1.
  - Parity is on `out` during cycle k+WIDTH.
  - `done` is high during cycle k+WIDTH+1 with parity, or k+WIDTH without it.
- `ones_cnt` reflects bits whose cycle has completed. A `1` driven in cycle c is counted from cycle c+1.
- `multi` therefore rises one cycle after the second `1` appears on `out`.
- Minimum start-to-start spacing is WIDTH+3 cycles with parity and WIDTH+2 without: the frame, DONE, then one IDLE cycle.

## Configuration
- The macro `SERIAL_PATTERN_GEN_PARITY_EN` controls the parity bit.
- **Defined:** the PARITY state exists and an even-parity bit follows the data bits.
- **Undefined:**
  - the PARITY state is not compiled;
  - SHIFT goes directly to DONE;
  - frame length is WIDTH+1 cycles including DONE.
- `ones_cnt` and `multi` never count the parity bit, in either build.

## Structure
- Shared package `serial_pkg` contains:
  - the state enum `sg_state_t` (IDLE, SHIFT, PARITY, DONE), 2-bit encoding;
  - the localparam function for counter width;
  - the constant `SG_PARITY_EVEN`.
- One natural sub-module is `serial_shifter`. It is a loadable left shift register with MSB tap and bit counter, exposes `load`, `shift` and `last`, and is instantiated once.
- The FSM, ones counter and parity logic live in the top module.

## Test plan
All scenarios use WIDTH=8 and a parity-enabled build unless noted.
1. **Two ones:** `data`=8'hA0, `start` pulse → `out` 1,0,1,0,0,0,0,0 then parity 0, then `done`. `multi` rises the cycle after the third bit. `ones_cnt` is 2 at `done`.
2. **Single one:** `data`=8'h01 → seven 0s then a 1, parity 1. `ones_cnt`=1 and `multi` stays 0 throughout.
3. **All zeros / all ones:**
   - `data`=8'h00 → all 0s, parity 0, `ones_cnt`=0.
   - `data`=8'hFF → `ones_cnt`=8, `multi` high from cycle 2 onward, parity 0.
4. **Start while busy:** pulse `start` with a different `data` at bit 3 of a frame → ignored; the original frame completes unchanged.
5. **Reset mid-frame:** assert `rst` during bit 4 → all outputs 0 immediately with no `done`. The next start then produces a clean full frame.
6. **Parity disabled, `start` held high:** build without the macro and hold `start`=1 → `done` at cycle k+8. The next frame is accepted after exactly one IDLE cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial pattern generator.
// Optional even-parity bit is controlled by SERIAL_PATTERN_GEN_PARITY_EN.
package serial_pkg;

  // Frame sequencing states. PARITY is only reachable when the parity build is enabled.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } sg_state_t;

  // XOR seed for the parity bit: 0 gives even parity over data plus parity.
  localparam logic SG_PARITY_EVEN = 1'b0;

  // Width of a counter that must hold values 0..w inclusive.
  function automatic int sg_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// Loadable left shift register with MSB tap and a bit counter.
// last is high while the final data bit (bit counter == WIDTH-1) is on the MSB tap.
module serial_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb,
  output logic             last
);

  localparam int BW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt;

  // Load captures the word and restarts the bit count; shift moves the next bit to the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (load) begin
      r_shreg   <= data;
      r_bit_cnt <= '0;
    end else if (shift) begin
      r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign msb  = r_shreg[WIDTH-1];
  assign last = (r_bit_cnt == BW'(WIDTH - 1));

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-stream generator: loads a word on start and shifts it out MSB-first,
// counting emitted ones. Define SERIAL_PATTERN_GEN_PARITY_EN to append an even-parity bit.
// Handshake: start is a level request sampled only in IDLE; the rising edge that sees
// start=1 in IDLE accepts the frame and captures data. start at any other time is ignored.
module serial_pattern_gen
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            data,
  output logic                        out,
  output logic                        busy,
  output logic                        done,
  output logic [sg_cnt_w(WIDTH)-1:0]  ones_cnt,
  output logic                        multi,
  output logic [1:0]                  dbg_state
);

  localparam int CW = sg_cnt_w(WIDTH);

  sg_state_t     r_state;
  sg_state_t     w_next;
  logic          w_load;
  logic          w_shift;
  logic          w_msb;
  logic          w_last;
  logic [CW-1:0] r_ones_cnt;

  serial_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .data  (data),
    .msb   (w_msb),
    .last  (w_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and shifter control.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (w_last) begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
          w_next = PARITY;
`else
          w_next = DONE;
`endif
        end
      end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      PARITY:  w_next = DONE;
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ones counter: a bit is counted on the edge that ends its cycle; parity is never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ones_cnt <= '0;
    else if (w_load)  r_ones_cnt <= '0;
    else if (w_shift) r_ones_cnt <= r_ones_cnt + CW'(w_msb);
  end

  // Serial line: data MSB while shifting; parity is the LSB of the full ones count.
  always_comb begin
    out = 1'b0;
    case (r_state)
      SHIFT:   out = w_msb;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
      PARITY:  out = r_ones_cnt[0] ^ SG_PARITY_EVEN;
`endif
      default: out = 1'b0;
    endcase
  end

  assign busy      = (r_state == SHIFT) || (r_state == PARITY);
  assign done      = (r_state == DONE);
  assign ones_cnt  = r_ones_cnt;
  assign multi     = (r_ones_cnt >= CW'(2));
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen (WIDTH=8), covering both parity builds.
module tb_serial_pattern_gen;

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       out;
  logic       busy;
  logic       done;
  logic [3:0] ones_cnt;
  logic       multi;
  logic [1:0] dbg_state;

  int n_tests;
  int n_fail;

  serial_pattern_gen #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .out       (out),
    .busy      (busy),
    .done      (done),
    .ones_cnt  (ones_cnt),
    .multi     (multi),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One frame with start pulsed; optionally pokes start with other data during bit poke_at.
  task automatic run_frame(input logic [7:0] d, input int exp_ones, input logic exp_par,
                           input int poke_at);
    int   run;
    logic b;
    run = 0;
    @(negedge clk); start = 1'b1; data = d;
    @(negedge clk); start = 1'b0; data = 8'($urandom_range(0, 255));
    for (int i = 0; i < W; i++) begin
      b = d[W-1-i];
      check($sformatf("bit%0d_out", i), 32'(out), 32'(b));
      check($sformatf("bit%0d_busy", i), 32'(busy), 32'd1);
      check($sformatf("bit%0d_done", i), 32'(done), 32'd0);
      check($sformatf("bit%0d_ones", i), 32'(ones_cnt), 32'(run));
      check($sformatf("bit%0d_multi", i), 32'(multi), 32'(run >= 2));
      if (i == poke_at) begin
        start = 1'b1;
        data  = ~d;
      end
      run += int'(b);
      @(negedge clk);
      start = 1'b0;
    end
    if (PAR == 1) begin
      check("par_out", 32'(out), 32'(exp_par));
      check("par_busy", 32'(busy), 32'd1);
      check("par_done", 32'(done), 32'd0);
      check("par_ones", 32'(ones_cnt), 32'(exp_ones));
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_out", 32'(out), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_ones", 32'(ones_cnt), 32'(exp_ones));
    check("done_multi", 32'(multi), 32'(exp_ones >= 2));
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ones_hold", 32'(ones_cnt), 32'(exp_ones));
  endtask

  initial begin
    int j;
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ones", 32'(ones_cnt), 32'd0);
    check("rst_multi", 32'(multi), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", 32'(busy), 32'd0);

    // Directed frames: data, ones, parity.
    run_frame(8'hA0, 2, 1'b0, -1);
    run_frame(8'h01, 1, 1'b1, -1);
    run_frame(8'h00, 0, 1'b0, -1);
    run_frame(8'hFF, 8, 1'b0, -1);
    run_frame(8'h3C, 4, 1'b0, 3);   // start while busy is ignored

    // Reset during bit 4 of a frame.
    @(negedge clk); start = 1'b1; data = 8'hFF;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ones", 32'(ones_cnt), 32'd0);
    check("mid_rst_multi", 32'(multi), 32'd0);
    @(negedge clk);
    check("mid_rst_no_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);
    run_frame(8'h96, 4, 1'b0, -1);

    // start held high: back-to-back frames with one IDLE cycle between.
    @(negedge clk); start = 1'b1; data = 8'h5A;
    @(negedge clk);
    j = 0;
    while (!done && j < 40) begin
      @(negedge clk);
      j++;
    end
    check("held_done_cycle", 32'(j), 32'(W + PAR));
    check("held_done_ones", 32'(ones_cnt), 32'd4);
    @(negedge clk);
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    check("held_restart_busy", 32'(busy), 32'd1);
    check("held_restart_out", 32'(out), 32'd0);
    check("held_restart_ones", 32'(ones_cnt), 32'd0);
    start = 1'b0;
    j = 0;
    while (!done && j < 40) begin
      @(negedge clk);
      j++;
    end
    check("held2_done_cycle", 32'(j), 32'(W + PAR));
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
